tennis_rally_fsm: RTL

Rally controller for the tennis game. It sits directly downstream of the clock divider and consumes its `divided_clk` as the ball-speed timebase. The divided clock is synchronised into the `clk_in` domain and turned into one-cycle move ticks. On each tick the block steps a one-hot ball across the LED court, evaluates player returns, keeps score and declares a winner.

---
 rtl/tennis_pkg.sv | 21 ++
 rtl/tennis_rally_fsm_edge_sync.sv | 28 ++
 rtl/tennis_rally_fsm.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tennis_pkg.sv
// Shared definitions for the tennis game: FSM states, side encoding and
// default game geometry.
package tennis_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_R,
        MOVE_L,
        POINT,
        GAME_OVER
    } state_t;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam int DEF_COURT_W     = 16;
    localparam int DEF_WIN_SCORE   = 7;
    localparam int DEF_SCORE_W     = 4;
    localparam int DEF_POINT_TICKS = 4;

endpackage

// File: rtl/tennis_rally_fsm_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector;
// emits a single-cycle pulse three clk edges after a rise on din.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/tennis_rally_fsm.sv
// Rally controller: steps a one-hot ball across the LED court on each
// divided-clock tick, evaluates returns, keeps score and declares a winner.
module tennis_rally_fsm
    import tennis_pkg::*;
#(
    parameter int COURT_W     = DEF_COURT_W,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int POINT_TICKS = DEF_POINT_TICKS
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               divided_clk,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               serve,
    output logic [COURT_W-1:0] led,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner
);

    localparam int PW = $clog2(COURT_W);
    localparam int FW = $clog2(POINT_TICKS + 1);
    localparam int unsigned HALF = COURT_W / 2;

    localparam logic [PW-1:0]      LAST       = PW'(COURT_W - 1);
    localparam logic [PW-1:0]      STEP       = PW'(1);
    localparam logic [COURT_W-1:0] BALL       = COURT_W'(1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] INC        = SCORE_W'(1);
    localparam logic [FW-1:0]      FLASH_LAST = FW'(POINT_TICKS - 1);
    localparam logic [FW-1:0]      FLASH_INC  = FW'(1);

    logic tick;
    logic hit_l_p;
    logic hit_r_p;
    logic serve_p;

    edge_sync u_tick  (.clk(clk_in), .rst(rst), .din(divided_clk), .pulse(tick));
    edge_sync u_btn_l (.clk(clk_in), .rst(rst), .din(btn_l),       .pulse(hit_l_p));
    edge_sync u_btn_r (.clk(clk_in), .rst(rst), .din(btn_r),       .pulse(hit_r_p));
    edge_sync u_serve (.clk(clk_in), .rst(rst), .din(serve),       .pulse(serve_p));

    state_t             state;
    logic [PW-1:0]      pos;
    logic               server;
    logic [FW-1:0]      flash;
    logic               hit_l_f;
    logic               hit_r_f;
    logic               moving;
    logic               eval_l;
    logic               eval_r;
    logic [COURT_W-1:0] low_half;

    always_comb begin
        moving = (state == MOVE_R) || (state == MOVE_L);
        eval_l = hit_l_f | hit_l_p;
        eval_r = hit_r_f | hit_r_p;
        low_half = '0;
        for (int unsigned i = 0; i < COURT_W; i++) begin
            low_half[i] = (i < HALF);
        end
    end

    // Flags live for one tick interval only, so an early press never carries over.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            hit_l_f <= 1'b0;
            hit_r_f <= 1'b0;
        end else if (tick) begin
            hit_l_f <= 1'b0;
            hit_r_f <= 1'b0;
        end else begin
            hit_l_f <= hit_l_f | (hit_l_p & moving);
            hit_r_f <= hit_r_f | (hit_r_p & moving);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pos       <= '0;
            server    <= LEFT;
            flash     <= '0;
            led       <= '0;
            score_l   <= '0;
            score_r   <= '0;
            game_over <= 1'b0;
            winner    <= LEFT;
        end else begin
            unique case (state)
                IDLE: begin
                    led <= '0;
                    if (serve_p) begin
                        if (server == LEFT) begin
                            pos   <= '0;
                            led   <= BALL;
                            state <= MOVE_R;
                        end else begin
                            pos   <= LAST;
                            led   <= BALL << LAST;
                            state <= MOVE_L;
                        end
                    end
                end
                MOVE_R: begin
                    if (tick) begin
                        if (pos < LAST) begin
                            pos <= pos + STEP;
                            led <= BALL << (pos + STEP);
                        end else if (eval_r) begin
                            pos   <= LAST - STEP;
                            led   <= BALL << (LAST - STEP);
                            state <= MOVE_L;
                        end else begin
                            if (score_l < WIN) score_l <= score_l + INC;
                            server <= RIGHT;
                            flash  <= '0;
                            led    <= '1;
                            state  <= POINT;
                        end
                    end
                end
                MOVE_L: begin
                    if (tick) begin
                        if (pos > '0) begin
                            pos <= pos - STEP;
                            led <= BALL << (pos - STEP);
                        end else if (eval_l) begin
                            pos   <= STEP;
                            led   <= BALL << STEP;
                            state <= MOVE_R;
                        end else begin
                            if (score_r < WIN) score_r <= score_r + INC;
                            server <= LEFT;
                            flash  <= '0;
                            led    <= '1;
                            state  <= POINT;
                        end
                    end
                end
                POINT: begin
                    if (tick) begin
                        if (flash == FLASH_LAST) begin
                            if (score_l == WIN) begin
                                winner    <= LEFT;
                                game_over <= 1'b1;
                                led       <= low_half;
                                state     <= GAME_OVER;
                            end else if (score_r == WIN) begin
                                winner    <= RIGHT;
                                game_over <= 1'b1;
                                led       <= ~low_half;
                                state     <= GAME_OVER;
                            end else begin
                                led   <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            flash <= flash + FLASH_INC;
                        end
                    end
                end
                GAME_OVER: begin
                    if (serve_p) begin
                        score_l   <= '0;
                        score_r   <= '0;
                        server    <= LEFT;
                        game_over <= 1'b0;
                        led       <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
